// File: rtl/ov7670_frame_capture.sv
// OV7670 frame-capture engine.
// Locks onto VSYNC frame boundaries, decodes 1- or 2-byte pixels, clips to the
// framebuffer geometry and emits registered framebuffer write strobes.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; clears clip on leaving
// S_SYNC    | waiting for vsync high so a frame already in flight is skipped
// S_ARMED   | in vertical blanking, waiting for vsync low to begin a frame
// S_CAPTURE | decoding href/d into pixel writes until the next vsync rise

module ov7670_frame_capture #(
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 2,
    parameter int BPP      = 2,
    parameter int BYTE_SEL = 0,
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic              pclk_12,
    input  logic              reset_n,
    input  logic              start,
    input  logic              single,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [PIX_W-1:0]  dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              clip
);

    localparam int ROW_W = $clog2(V_LINES + 1);

    localparam logic [ADDR_W-1:0] H_A      = ADDR_W'(H_PIXELS);
    localparam logic [ROW_W-1:0]  V_R      = ROW_W'(V_LINES);
    localparam logic              PH_SEL   = 1'(BYTE_SEL);
    localparam logic              PH_LAST  = 1'(BPP - 1);

    // Geometry and pixel-format sanity checks at elaboration.
    if (longint'(H_PIXELS) * longint'(V_LINES) > (longint'(1) << ADDR_W)) begin : g_geom_err
        $error("ov7670_frame_capture: H_PIXELS*V_LINES exceeds 2**ADDR_W");
    end
    if (BPP < 1 || BPP > 2) begin : g_bpp_err
        $error("ov7670_frame_capture: BPP must be 1 or 2");
    end
    if (BYTE_SEL < 0 || BYTE_SEL >= BPP) begin : g_sel_err
        $error("ov7670_frame_capture: BYTE_SEL must be in 0..BPP-1");
    end
    if (PIX_W < 1 || PIX_W > 8) begin : g_pixw_err
        $error("ov7670_frame_capture: PIX_W must be in 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_ARMED,
        S_CAPTURE
    } state_t;

    state_t              state;
    logic                single_q;
    logic                href_q;
    logic                vsync_q;
    logic                phase;
    logic [ADDR_W-1:0]   col;
    logic [ADDR_W-1:0]   line_base;
    logic [ROW_W-1:0]    row;

    // Capture FSM with all outputs and pixel/line counters registered.
    always_ff @(posedge pclk_12) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            single_q    <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            phase       <= 1'b0;
            col         <= '0;
            line_base   <= '0;
            row         <= '0;
            addr        <= '0;
            dout        <= '0;
            we          <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            clip        <= 1'b0;
        end else begin
            href_q     <= href;
            vsync_q    <= vsync;
            we         <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SYNC;
                        busy  <= 1'b1;
                        clip  <= 1'b0;
                    end
                end

                S_SYNC: begin
                    if (vsync) begin
                        state    <= S_ARMED;
                        single_q <= single;
                    end
                end

                S_ARMED: begin
                    if (!vsync) begin
                        state     <= S_CAPTURE;
                        col       <= '0;
                        row       <= '0;
                        line_base <= '0;
                        phase     <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    if (vsync && !vsync_q) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        if (single_q || !start) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_ARMED;
                            single_q <= single;
                        end
                    end else if (!vsync) begin
                        if (href) begin
                            phase <= (phase == PH_LAST) ? 1'b0 : phase + 1'b1;
                            if (phase == PH_SEL) begin
                                if (col < H_A && row < V_R) begin
                                    we   <= 1'b1;
                                    dout <= PIX_W'(d >> (8 - PIX_W));
                                    addr <= line_base + col;
                                end else begin
                                    clip <= 1'b1;
                                end
                                if (col != H_A) begin
                                    col <= col + 1'b1;
                                end
                            end
                        end else if (href_q) begin
                            // End of line: later lines keep their base even if this one was short.
                            if (row < V_R) begin
                                row       <= row + 1'b1;
                                line_base <= line_base + H_A;
                            end
                            col   <= '0;
                            phase <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
